bcd_count_driver: RTL and testbench

//  Stimulus/readback master for the JK ripple decade counter (q1,q2,q4,q8; count/active-low reset).

---
 rtl/bcd_count_driver.sv | 166 ++++++++++++++++
 tb/tb_bcd_count_driver.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/bcd_count_driver.sv
// Load a BCD digit into a JK ripple decade counter as N count pulses and read it back.
// Define BCD_DRV_READBACK_EN to build the synchroniser, settle wait and readback compare.
module bcd_count_driver #(
  parameter int PULSE_HI = 2,
  parameter int PULSE_LO = 2,
  parameter int SETTLE   = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] digit,
  input  logic       q1,
  input  logic       q2,
  input  logic       q4,
  input  logic       q8,
  output logic       ctr_count,
  output logic       ctr_reset_n,
  output logic       busy,
  output logic       done,
  output logic       match,
  output logic       error
);

  localparam int MAX_HL = (PULSE_HI > PULSE_LO) ? PULSE_HI : PULSE_LO;
  localparam int MAX_T  = (MAX_HL > SETTLE) ? MAX_HL : SETTLE;
  localparam int TW     = $clog2(MAX_T) + 1;

  localparam logic [TW-1:0] CLR_LD = TW'(1);
  localparam logic [TW-1:0] HI_LD  = TW'(PULSE_HI - 1);
  localparam logic [TW-1:0] LO_LD  = TW'(PULSE_LO - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_HIGH, S_LOW, S_SETTLE, S_CHECK
  } state_t;

  // Where the FSM goes once the last pulse (or the clear, for digit 0) is finished.
`ifdef BCD_DRV_READBACK_EN
  localparam state_t        TAIL    = S_SETTLE;
  localparam logic [TW-1:0] TAIL_LD = TW'(SETTLE - 1);
`else
  localparam state_t        TAIL    = S_CHECK;
  localparam logic [TW-1:0] TAIL_LD = '0;
`endif

  state_t          state, state_nxt;
  logic [TW-1:0]   timer, timer_nxt;
  logic [3:0]      n, n_nxt;
  logic            count_nxt, reset_n_nxt, busy_nxt, done_nxt, match_nxt, error_nxt;
  logic            accept;

`ifdef BCD_DRV_READBACK_EN
  logic [3:0] q_sync_p0, q_sync_p1;
  logic [3:0] digit_lat;

  // Stage p0/p1: two-flop synchroniser on the asynchronous ripple outputs
  always_ff @(posedge clock) begin
    q_sync_p0 <= {q8, q4, q2, q1};
    q_sync_p1 <= q_sync_p0;
    if (accept) digit_lat <= digit;
  end
`else
  logic unused_q;
  assign unused_q = ^{q8, q4, q2, q1};
`endif

  assign accept = (state == S_IDLE) && start && (digit <= 4'd9);

  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    n_nxt     = n;
    error_nxt = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (digit <= 4'd9) begin
            state_nxt = S_CLEAR;
            timer_nxt = CLR_LD;
            n_nxt     = digit;
          end else begin
            error_nxt = 1'b1;
          end
        end
      end
      S_CLEAR: begin
        if (timer == '0) begin
          if (n != 4'd0) begin
            state_nxt = S_HIGH;
            timer_nxt = HI_LD;
          end else begin
            state_nxt = TAIL;
            timer_nxt = TAIL_LD;
          end
        end else begin
          timer_nxt = timer - 1'b1;
        end
      end
      S_HIGH: begin
        if (timer == '0) begin
          state_nxt = S_LOW;
          timer_nxt = LO_LD;
        end else begin
          timer_nxt = timer - 1'b1;
        end
      end
      S_LOW: begin
        if (timer == '0) begin
          n_nxt = n - 4'd1;
          if (n == 4'd1) begin
            state_nxt = TAIL;
            timer_nxt = TAIL_LD;
          end else begin
            state_nxt = S_HIGH;
            timer_nxt = HI_LD;
          end
        end else begin
          timer_nxt = timer - 1'b1;
        end
      end
      S_SETTLE: begin
        if (timer == '0) state_nxt = S_CHECK;
        else             timer_nxt = timer - 1'b1;
      end
      S_CHECK: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase

    // Outputs are registered from the next state so they line up with the state itself.
    count_nxt   = (state_nxt == S_HIGH);
    reset_n_nxt = (state_nxt != S_CLEAR);
    busy_nxt    = (state_nxt != S_IDLE);
    done_nxt    = (state_nxt == S_CHECK);
`ifdef BCD_DRV_READBACK_EN
    match_nxt = match;
    if (accept)                  match_nxt = 1'b0;
    else if (state_nxt == S_CHECK) match_nxt = (q_sync_p1 == digit_lat);
`else
    match_nxt = 1'b0;
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= S_IDLE;
      timer       <= '0;
      n           <= '0;
      ctr_count   <= 1'b0;
      ctr_reset_n <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      match       <= 1'b0;
      error       <= 1'b0;
    end else begin
      state       <= state_nxt;
      timer       <= timer_nxt;
      n           <= n_nxt;
      ctr_count   <= count_nxt;
      ctr_reset_n <= reset_n_nxt;
      busy        <= busy_nxt;
      done        <= done_nxt;
      match       <= match_nxt;
      error       <= error_nxt;
    end
  end

endmodule

// File: tb/tb_bcd_count_driver.sv
// Bench for bcd_count_driver with a behavioural decade counter; follows BCD_DRV_READBACK_EN if defined.
module tb_bcd_count_driver;

  localparam int PH = 2;
  localparam int PL = 2;
  localparam int ST = 4;
`ifdef BCD_DRV_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset, start;
  logic [3:0] digit;
  logic       q1, q2, q4, q8;
  logic       ctr_count, ctr_reset_n, busy, done, match, error;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural decade counter: clears while ctr_reset_n low, advances on count rise.
  logic [3:0] cnt;
  int         rises = 0;
  bit         stuck_q4 = 1'b0;

  always @(posedge ctr_count or negedge ctr_reset_n) begin
    if (!ctr_reset_n) cnt <= 4'd0;
    else              cnt <= (cnt >= 4'd9) ? 4'd0 : cnt + 4'd1;
  end

  always @(posedge ctr_count) rises <= rises + 1;

  assign q1 = cnt[0];
  assign q2 = cnt[1];
  assign q4 = stuck_q4 ? 1'b0 : cnt[2];
  assign q8 = cnt[3];

  always #5 clock = ~clock;

  bcd_count_driver #(.PULSE_HI(PH), .PULSE_LO(PL), .SETTLE(ST)) dut (
    .clock(clock), .reset(reset), .start(start), .digit(digit),
    .q1(q1), .q2(q2), .q4(q4), .q8(q8),
    .ctr_count(ctr_count), .ctr_reset_n(ctr_reset_n), .busy(busy),
    .done(done), .match(match), .error(error)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // One load request; g>0 pulses a stray start in that cycle, g<0 pulses it in the done cycle.
  task automatic do_req(input logic [3:0] d, input bit stuck, input int g);
    int     dd, exp_lat, cyc, clr, r0;
    bit     seen, busy_ok;
    logic [3:0] seen_val;
    logic   exp_m;
    dd       = int'(d);
    stuck_q4 = stuck;
    exp_lat  = 2 + dd * (PH + PL) + (RB ? ST : 0) + 1;
    seen_val = stuck ? (d & 4'b1011) : d;
    exp_m    = RB && (seen_val == d);
    if (g < 0) g = exp_lat;
    @(negedge clock);
    start = 1'b1;
    digit = d;
    r0    = rises;
    @(posedge clock); #1;
    start   = 1'b0;
    cyc     = 1;
    clr     = 0;
    seen    = 1'b0;
    busy_ok = 1'b1;
    while (cyc < 200) begin
      if (!ctr_reset_n) clr++;
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (cyc == g) begin
        start = 1'b1;
        digit = 4'd1;
      end
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      @(posedge clock); #1;
      start = 1'b0;
      cyc++;
    end
    chk("done_seen", 32'(seen), 32'd1);
    chk("latency", cyc, exp_lat);
    chk("busy_during", 32'(busy_ok), 32'd1);
    chk("clear_cycles", clr, 2);
    chk("count_rises", rises - r0, dd);
    chk("counter_value", 32'(cnt), 32'(d));
    chk("match", 32'(match), 32'(exp_m));
    @(posedge clock); #1;
    start = 1'b0;
    chk("busy_after", 32'(busy), 32'd0);
    chk("done_after", 32'(done), 32'd0);
    chk("reset_n_after", 32'(ctr_reset_n), 32'd1);
    stuck_q4 = 1'b0;
  endtask

  task automatic do_err(input logic [3:0] d);
    @(negedge clock);
    start = 1'b1;
    digit = d;
    @(posedge clock); #1;
    start = 1'b0;
    chk("error_strobe", 32'(error), 32'd1);
    chk("error_busy", 32'(busy), 32'd0);
    chk("error_reset_n", 32'(ctr_reset_n), 32'd1);
    chk("error_count", 32'(ctr_count), 32'd0);
    @(posedge clock); #1;
    chk("error_one_cycle", 32'(error), 32'd0);
    chk("error_busy2", 32'(busy), 32'd0);
  endtask

  initial begin
    bit found, no_done;
    reset = 1'b1;
    start = 1'b0;
    digit = 4'd0;

    for (int i = 0; i < 3; i++) begin
      @(posedge clock); #1;
      chk("rst_outputs", {26'd0, ctr_count, ctr_reset_n, busy, done, match, error}, 32'd0);
    end
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock); #1;
    chk("rst_release_reset_n", 32'(ctr_reset_n), 32'd1);
    chk("rst_release_busy", 32'(busy), 32'd0);

    do_req(4'd7, 1'b0, 0);
    do_req(4'd0, 1'b0, 0);
    do_req(4'd9, 1'b0, 0);
    do_err(4'd12);
    do_req(4'd4, 1'b0, 3);
    do_req(4'd3, 1'b0, -1);

    // Abort a digit-5 load with reset while ctr_count is high.
    @(negedge clock);
    start = 1'b1;
    digit = 4'd5;
    @(posedge clock); #1;
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (ctr_count === 1'b1) begin
        found = 1'b1;
        break;
      end
      @(posedge clock); #1;
    end
    chk("abort_reach_high", 32'(found), 32'd1);
    reset = 1'b1;
    @(posedge clock); #1;
    chk("abort_count", 32'(ctr_count), 32'd0);
    chk("abort_reset_n", 32'(ctr_reset_n), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    @(posedge clock); #1;
    chk("abort_counter_cleared", 32'(cnt), 32'd0);
    @(negedge clock);
    reset   = 1'b0;
    no_done = 1'b1;
    for (int i = 0; i < 25; i++) begin
      @(posedge clock); #1;
      if (done !== 1'b0 || busy !== 1'b0) no_done = 1'b0;
    end
    chk("abort_no_done", 32'(no_done), 32'd1);

    do_req(4'd6, 1'b1, 0);

    for (int k = 0; k < 6; k++) begin
      logic [3:0] rd;
      int         rg;
      rd = 4'($urandom_range(0, 9));
      rg = ($urandom_range(0, 1) == 1) ? int'($urandom_range(3, 6)) : 0;
      do_req(rd, 1'b0, rg);
    end
    for (int k = 0; k < 2; k++) do_err(4'($urandom_range(10, 15)));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
